id_ex_stage: RTL and testbench

- ID/EX pipeline boundary of the 32-bit, 5-stage MIPS core.
- Sits directly downstream of the register file. Captures the two read operands, the decoded control fields and the sign-extended immediate, and presents them to the EX stage.
- Contains the load-use hazard detector, which stalls PC and IF/ID and inserts a bubble.
- Contains an optional WB→ID write-through bypass, which covers the register file's same-cycle write/read case.

---
 rtl/core_pkg.sv | 36 +++
 rtl/hazard_detect.sv | 34 +++
 rtl/id_ex_stage.sv | 153 +++++++++++++++
 tb/tb_id_ex_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared types and widths for the 5-stage MIPS core pipeline.
//   DATA_W / REG_AW : datapath and register-address widths
//   ctrl_t          : 9-bit decoded control bundle, MSB first:
//                     {reg_dst, alu_src, mem_to_reg, reg_write,
//                      mem_read, mem_write, branch, alu_op[1:0]}
//   CTRL_*_BIT      : bit offsets of each field inside the flat 9-bit vector
//   CTRL_NOP        : all-zero bundle, used as the pipeline bubble
package core_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 9;

  localparam int CTRL_REG_DST_BIT    = 8;
  localparam int CTRL_ALU_SRC_BIT    = 7;
  localparam int CTRL_MEM_TO_REG_BIT = 6;
  localparam int CTRL_REG_WRITE_BIT  = 5;
  localparam int CTRL_MEM_READ_BIT   = 4;
  localparam int CTRL_MEM_WRITE_BIT  = 3;
  localparam int CTRL_BRANCH_BIT     = 2;
  localparam int CTRL_ALU_OP_LSB     = 0;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use hazard detector.
//   id_valid, id_rs, id_rt, id_uses_rt : instruction currently in ID
//   ex_valid, ex_mem_read, ex_rt       : instruction currently in EX
//   flush                              : ID instruction is being squashed
//   haz                                : raw load-use condition
//   stall                              : hold PC and IF/ID (haz gated by flush)
module hazard_detect #(
  parameter int REG_AW = core_pkg::REG_AW
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              flush,
  output logic              haz,
  output logic              stall
);

  logic rs_match;
  logic rt_match;

  // $zero is never a real producer, so a load into r0 never stalls.
  assign rs_match = (ex_rt == id_rs);
  assign rt_match = id_uses_rt && (ex_rt == id_rt);
  assign haz      = id_valid && ex_valid && ex_mem_read && (ex_rt != '0)
                    && (rs_match || rt_match);

  // A squashed ID instruction has no dependency worth waiting for.
  assign stall    = haz && !flush;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage MIPS core.
//   Inputs : ID instruction fields (id_*), register file read data (rd_data*),
//            WB write port (wb_*), flush from branch/jump resolution.
//   Outputs: stall (combinational, holds PC and IF/ID), registered EX fields
//            (ex_*), saturating stall-cycle counter stall_cnt.
// Optional build macro ID_EX_WB_BYPASS_EN: forward the WB write data into the
//   captured operands when WB writes the register being read this cycle.
//   Without it the WB ports are present but unused.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int DATA_W = core_pkg::DATA_W,
  parameter int REG_AW = core_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] rd_data1,
  input  logic [DATA_W-1:0] rd_data2,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_data1,
  output logic [DATA_W-1:0] ex_data2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              valid_q, valid_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [REG_AW-1:0] rt_q, rt_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic [DATA_W-1:0] data2_q, data2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              haz;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rt       (rt_q),
    .flush       (flush),
    .haz         (haz),
    .stall       (stall)
  );

`ifdef ID_EX_WB_BYPASS_EN
  logic fwd1;
  logic fwd2;

  // The regfile write lands on the same edge we capture, so its read port
  // still shows the old value; take the WB data directly instead.
  assign fwd1 = wb_reg_write && (wb_write_reg != '0) && (wb_write_reg == id_rs);
  assign fwd2 = wb_reg_write && (wb_write_reg != '0) && (wb_write_reg == id_rt);
  assign op1  = fwd1 ? wb_write_data : rd_data1;
  assign op2  = fwd2 ? wb_write_data : rd_data2;
`else
  logic unused_wb;

  assign op1       = rd_data1;
  assign op2       = rd_data2;
  assign unused_wb = ^{wb_reg_write, wb_write_reg, wb_write_data};
`endif

  always_comb begin
    valid_d = 1'b0;
    rs_d    = '0;
    rt_d    = '0;
    rd_d    = '0;
    data1_d = '0;
    data2_d = '0;
    imm_d   = '0;
    ctrl_d  = CTRL_NOP;
    // Flush or load-use hazard: leave the all-zero bubble.
    if (!flush && !haz) begin
      valid_d = id_valid;
      rs_d    = id_rs;
      rt_d    = id_rt;
      rd_d    = id_rd;
      data1_d = op1;
      data2_d = op2;
      imm_d   = id_imm;
      ctrl_d  = id_valid ? ctrl_t'(id_ctrl) : CTRL_NOP;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      data1_q     <= '0;
      data2_q     <= '0;
      imm_q       <= '0;
      ctrl_q      <= CTRL_NOP;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      imm_q       <= imm_d;
      ctrl_q      <= ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid  = valid_q;
  assign ex_rs     = rs_q;
  assign ex_rt     = rt_q;
  assign ex_rd     = rd_q;
  assign ex_data1  = data1_q;
  assign ex_data2  = data2_q;
  assign ex_imm    = imm_q;
  assign ex_ctrl   = ctrl_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized and directed bench for id_ex_stage against a
// behavioural model of the EX-side instruction slot. A second instance with a
// 4-bit stall counter exercises saturation. Honours ID_EX_WB_BYPASS_EN.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rt;
  logic [31:0] id_imm;
  logic [8:0]  id_ctrl;
  logic [31:0] rd_data1, rd_data2;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        flush;

  logic        stall, stall4;
  logic        ex_valid, ex_valid4;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_rs4, ex_rt4, ex_rd4;
  logic [31:0] ex_data1, ex_data2, ex_imm, ex_data14, ex_data24, ex_imm4;
  logic [8:0]  ex_ctrl, ex_ctrl4;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt4;

  always #5 clk = ~clk;

  id_ex_stage u_dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .wb_reg_write(wb_reg_write),
    .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .wb_reg_write(wb_reg_write),
    .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data), .flush(flush),
    .stall(stall4), .ex_valid(ex_valid4), .ex_rs(ex_rs4), .ex_rt(ex_rt4), .ex_rd(ex_rd4),
    .ex_data1(ex_data14), .ex_data2(ex_data24), .ex_imm(ex_imm4), .ex_ctrl(ex_ctrl4),
    .stall_cnt(stall_cnt4)
  );

  localparam logic [8:0] LW_CTRL  = 9'b011110000;  // alu_src, mem_to_reg, reg_write, mem_read
  localparam logic [8:0] ADD_CTRL = 9'b100100010;  // reg_dst, reg_write, alu_op=10

  // What the model believes sits in EX.
  typedef struct packed {
    logic        v;
    logic [4:0]  rs, rt, rd;
    logic [31:0] d1, d2, imm;
    logic [8:0]  ctrl;
  } ex_t;

  ex_t m;
  int  stall_total;
  int  n_checks;
  int  n_err;
  logic pre_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_haz();
    return id_valid && m.v && m.ctrl[4] && (m.rt != 5'd0) &&
           ((m.rt == id_rs) || (id_uses_rt && (m.rt == id_rt)));
  endfunction

  function automatic logic [31:0] model_operand(input logic [4:0] src, input logic [31:0] rf);
`ifdef ID_EX_WB_BYPASS_EN
    if (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == src)) return wb_write_data;
`endif
    if (src == 5'd31) return rf;  // keeps src referenced in both builds
    return rf;
  endfunction

  // Entered just after a falling edge with inputs already driven; returns
  // just after the next falling edge.
  task automatic step();
    logic exp_stall;
    ex_t  nx;
    int   exp16, exp4;
    #1;
    exp_stall = model_haz() && !flush;
    pre_stall = stall;
    chk("stall", {31'd0, stall}, {31'd0, exp_stall});
    chk("stall_w4", {31'd0, stall4}, {31'd0, exp_stall});
    nx = '0;
    if (reset) begin
      stall_total = 0;
    end else if (flush || model_haz()) begin
      if (exp_stall) stall_total++;
    end else begin
      nx.v    = id_valid;
      nx.rs   = id_rs;
      nx.rt   = id_rt;
      nx.rd   = id_rd;
      nx.d1   = model_operand(id_rs, rd_data1);
      nx.d2   = model_operand(id_rt, rd_data2);
      nx.imm  = id_imm;
      nx.ctrl = id_valid ? id_ctrl : 9'd0;
    end
    @(posedge clk);
    #1;
    m = nx;
    exp16 = (stall_total > 65535) ? 65535 : stall_total;
    exp4  = (stall_total > 15) ? 15 : stall_total;
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m.v});
    chk("ex_rs", {27'd0, ex_rs}, {27'd0, m.rs});
    chk("ex_rt", {27'd0, ex_rt}, {27'd0, m.rt});
    chk("ex_rd", {27'd0, ex_rd}, {27'd0, m.rd});
    chk("ex_data1", ex_data1, m.d1);
    chk("ex_data2", ex_data2, m.d2);
    chk("ex_imm", ex_imm, m.imm);
    chk("ex_ctrl", {23'd0, ex_ctrl}, {23'd0, m.ctrl});
    chk("stall_cnt", {16'd0, stall_cnt}, exp16);
    chk("stall_cnt_w4", {28'd0, stall_cnt4}, exp4);
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rt = 0;
    id_imm = 0; id_ctrl = 0; rd_data1 = 0; rd_data2 = 0; wb_reg_write = 0;
    wb_write_reg = 0; wb_write_data = 0; flush = 0;
  endtask

  task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic uses_rt, input logic [8:0] ctrl);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = uses_rt; id_ctrl = ctrl;
    id_imm = $urandom; rd_data1 = $urandom; rd_data2 = $urandom;
  endtask

  task automatic rand_inputs();
    id_valid      = ($urandom_range(0, 9) != 0);
    id_rs         = 5'($urandom_range(0, 3));
    id_rt         = 5'($urandom_range(0, 3));
    id_rd         = 5'($urandom);
    id_uses_rt    = 1'($urandom);
    id_imm        = $urandom;
    id_ctrl       = 9'($urandom);
    rd_data1      = $urandom;
    rd_data2      = $urandom;
    wb_reg_write  = 1'($urandom);
    wb_write_reg  = 5'($urandom_range(0, 3));
    wb_write_data = $urandom;
    flush         = ($urandom_range(0, 9) == 0);
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    reset = 0;
  endtask

  initial begin
    m = '0; stall_total = 0; n_checks = 0; n_err = 0; pre_stall = 0;
    idle();
    @(negedge clk);

    // Reset held 3 cycles with random inputs.
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      reset = 1;
      step();
    end
    idle();
    step();
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_ex_ctrl", {23'd0, ex_ctrl}, 32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_stall", {31'd0, pre_stall}, 32'd0);

    // Load-use: lw $t0 then add using $t0.
    set_instr(5'd2, 5'd8, 5'd0, 1'b0, LW_CTRL);
    step();
    set_instr(5'd8, 5'd9, 5'd10, 1'b1, ADD_CTRL);
    step();
    chk("lu_stall", {31'd0, pre_stall}, 32'd1);
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_ctrl", {23'd0, ex_ctrl}, 32'd0);
    chk("lu_cnt", {16'd0, stall_cnt}, 32'd1);
    step();
    chk("lu_release_stall", {31'd0, pre_stall}, 32'd0);
    chk("lu_add_ctrl", {23'd0, ex_ctrl}, 32'h122);
    chk("lu_add_rs", {27'd0, ex_rs}, 32'd8);

    // Load into r0 never stalls; rt not used as a source never stalls.
    set_instr(5'd2, 5'd0, 5'd0, 1'b0, LW_CTRL);
    step();
    set_instr(5'd0, 5'd0, 5'd10, 1'b1, ADD_CTRL);
    step();
    chk("r0_no_stall", {31'd0, pre_stall}, 32'd0);
    set_instr(5'd2, 5'd8, 5'd0, 1'b0, LW_CTRL);
    step();
    set_instr(5'd9, 5'd8, 5'd10, 1'b0, ADD_CTRL);
    step();
    chk("no_rt_use_stall", {31'd0, pre_stall}, 32'd0);
    chk("no_rt_use_valid", {31'd0, ex_valid}, 32'd1);

    // Flush coincident with load-use.
    set_instr(5'd2, 5'd8, 5'd0, 1'b0, LW_CTRL);
    step();
    set_instr(5'd8, 5'd9, 5'd10, 1'b1, ADD_CTRL);
    flush = 1;
    step();
    flush = 0;
    chk("flush_stall", {31'd0, pre_stall}, 32'd0);
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_cnt", {16'd0, stall_cnt}, 32'd1);

    // WB write-through.
    set_instr(5'd17, 5'd3, 5'd4, 1'b1, ADD_CTRL);
    rd_data1 = 32'h0; wb_reg_write = 1; wb_write_reg = 5'd17; wb_write_data = 32'hDEADBEEF;
    step();
`ifdef ID_EX_WB_BYPASS_EN
    chk("bypass_data1", ex_data1, 32'hDEADBEEF);
`else
    chk("bypass_data1", ex_data1, 32'h0);
`endif
    set_instr(5'd0, 5'd3, 5'd4, 1'b1, ADD_CTRL);
    rd_data1 = 32'h0; wb_reg_write = 1; wb_write_reg = 5'd0; wb_write_data = 32'hDEADBEEF;
    step();
    chk("bypass_r0", ex_data1, 32'h0);
    idle();

    // Saturation: 25 load-use pairs from reset.
    do_reset();
    for (int i = 0; i < 25; i++) begin
      set_instr(5'd2, 5'd8, 5'd0, 1'b0, LW_CTRL);
      step();
      set_instr(5'd8, 5'd9, 5'd10, 1'b1, ADD_CTRL);
      step();
    end
    chk("sat_cnt4", {28'd0, stall_cnt4}, 32'hF);
    chk("sat_cnt16", {16'd0, stall_cnt}, 32'd25);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      rand_inputs();
      reset = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
